// File: rtl/reggy_pipe.sv
// Multi-stage pipeline register with stall, flush, back-pressure and an
// optional bubble-collapsing mode. Stage 0 takes the input; stage DEPTH-1 drives the output.
module reggy_pipe #(
    parameter int             W         = 8,
    parameter int             DEPTH     = 2,
    parameter bit             COLLAPSE  = 1'b0,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic [W-1:0]               out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]     data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [CW-1:0]    count_r;

    logic [W-1:0]     src_d_s [DEPTH];
    logic [DEPTH-1:0] src_v_s;
    logic [DEPTH-1:0] en_s;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             accept_s;
    logic             retire_s;

    // Each stage's load source: the input for stage 0, the previous stage otherwise.
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_d_s[k] = in_data;
            assign src_v_s[k] = in_valid;
        end else begin : g_body
            assign src_d_s[k] = data_r[k-1];
            assign src_v_s[k] = valid_r[k-1];
        end
    end

    // Stage enables; in collapse mode a stage advances if any slot at or beyond it is empty.
    always_comb begin : p_enable
        logic tail_full_s;
        tail_full_s = 1'b1;
        en_s        = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            tail_full_s = tail_full_s & valid_r[k];
            if (COLLAPSE) begin
                en_s[k] = !stall || !tail_full_s;
            end else begin
                en_s[k] = !stall;
            end
        end
    end

    // Next valid bits and occupancy; flush overrides both stall and load.
    always_comb begin
        accept_s = in_valid & en_s[0];
        retire_s = valid_r[DEPTH-1] & !stall;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush) begin
                valid_nxt_s[k] = 1'b0;
            end else if (en_s[k]) begin
                valid_nxt_s[k] = src_v_s[k];
            end else begin
                valid_nxt_s[k] = valid_r[k];
            end
        end
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + CW'(accept_s) - CW'(retire_s);
        end
    end

    // Stage data, valid and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k] <= RESET_VAL;
            end
            valid_r <= '0;
            count_r <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (en_s[k]) begin
                    data_r[k] <= src_d_s[k];
                end else begin
                    data_r[k] <= data_r[k];
                end
            end
            valid_r <= valid_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign in_ready  = en_s[0];
    assign out_data  = data_r[DEPTH-1];
    assign out_valid = valid_r[DEPTH-1];
    assign count     = count_r;

endmodule

// File: tb/tb_reggy_pipe.sv
// Randomised and directed bench for reggy_pipe: three configurations driven by the
// same stimulus and compared against a slot-level reference model.
module tb_reggy_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       stall;
    logic       flush;

    logic [7:0] od [3];
    logic       ov [3];
    logic       ir [3];
    logic [1:0] c0, c1;
    logic       c2;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int DEP [3] = '{3, 3, 1};
    localparam bit COL [3] = '{1'b0, 1'b1, 1'b1};

    bit         mv [3][3];
    logic [7:0] md [3][3];
    int         mc [3];

    always #5 clk = ~clk;

    reggy_pipe #(.W(8), .DEPTH(3), .COLLAPSE(1'b0), .RESET_VAL(8'hA5)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .stall(stall), .flush(flush), .out_data(od[0]), .out_valid(ov[0]), .count(c0));
    reggy_pipe #(.W(8), .DEPTH(3), .COLLAPSE(1'b1), .RESET_VAL(8'hA5)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .stall(stall), .flush(flush), .out_data(od[1]), .out_valid(ov[1]), .count(c1));
    reggy_pipe #(.W(8), .DEPTH(1), .COLLAPSE(1'b1), .RESET_VAL(8'hA5)) u2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
        .stall(stall), .flush(flush), .out_data(od[2]), .out_valid(ov[2]), .count(c2));

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int obs_count(input int c);
        if (c == 0) return int'(c0);
        if (c == 1) return int'(c1);
        return int'(c2);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            mc[c] = 0;
            for (int k = 0; k < 3; k++) begin
                mv[c][k] = 1'b0;
                md[c][k] = 8'hA5;
            end
        end
    endtask

    // Check in_ready against the current inputs, then advance the model by one edge.
    task automatic model_edge(input int c);
        int dep;
        bit en [3];
        bit bubble;
        bit last_v;
        dep    = DEP[c];
        last_v = mv[c][dep-1];
        for (int k = 0; k < dep; k++) begin
            bubble = 1'b0;
            for (int j = k; j < dep; j++) begin
                if (!mv[c][j]) bubble = 1'b1;
            end
            en[k] = COL[c] ? (!stall || bubble) : !stall;
        end
        chk($sformatf("in_ready[%0d]", c), int'(ir[c]), int'(en[0]));
        if (flush) mc[c] = 0;
        else       mc[c] = mc[c] + int'(in_valid && en[0]) - int'(last_v && !stall);
        for (int k = dep - 1; k >= 1; k--) begin
            if (en[k]) begin
                mv[c][k] = mv[c][k-1];
                md[c][k] = md[c][k-1];
            end
        end
        if (en[0]) begin
            mv[c][0] = in_valid;
            md[c][0] = in_data;
        end
        if (flush) begin
            for (int k = 0; k < dep; k++) mv[c][k] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("out_valid[%0d]", c), int'(ov[c]), int'(mv[c][DEP[c]-1]));
            if (mv[c][DEP[c]-1]) begin
                chk($sformatf("out_data[%0d]", c), int'(od[c]), int'(md[c][DEP[c]-1]));
            end
            chk($sformatf("count[%0d]", c), obs_count(c), mc[c]);
        end
    endtask

    task automatic cycle(input logic [7:0] d, input logic v, input logic s, input logic f);
        in_data  = d;
        in_valid = v;
        stall    = s;
        flush    = f;
        #1;
        for (int c = 0; c < 3; c++) model_edge(c);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Assert reset between edges and verify the outputs react without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_valid[%0d]", c), int'(ov[c]), 0);
            chk($sformatf("rst_data[%0d]", c), int'(od[c]), 32'hA5);
            chk($sformatf("rst_count[%0d]", c), obs_count(c), 0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        model_clear();
        #3;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("por_valid[%0d]", c), int'(ov[c]), 0);
            chk($sformatf("por_data[%0d]", c), int'(od[c]), 32'hA5);
        end
        @(negedge clk);
        rst = 1'b0;

        // Streaming: 0x11 reaches the output of the 3-deep pipe after the third edge.
        cycle(8'h11, 1'b1, 1'b0, 1'b0);
        cycle(8'h22, 1'b1, 1'b0, 1'b0);
        cycle(8'h33, 1'b1, 1'b0, 1'b0);
        chk("stream_first", int'(od[0]), 32'h11);
        chk("stream_count", int'(c0), 3);
        // Global stall with a full pipe, then release.
        cycle(8'h44, 1'b1, 1'b1, 1'b0);
        cycle(8'h44, 1'b1, 1'b1, 1'b0);
        chk("stall_hold", int'(od[0]), 32'h11);
        cycle(8'h44, 1'b1, 1'b0, 1'b0);
        chk("stall_resume", int'(od[0]), 32'h22);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);

        // Collapse: A, bubble, B, then stall lets B and C close up behind A.
        cycle(8'hA1, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'hB2, 1'b1, 1'b0, 1'b0);
        cycle(8'hC3, 1'b1, 1'b1, 1'b0);
        cycle(8'hD4, 1'b1, 1'b1, 1'b0);
        chk("collapse_full", int'(c1), 3);
        chk("collapse_head", int'(od[1]), 32'hA1);

        // Flush a full pipe while offering an input that must never emerge.
        cycle(8'hEE, 1'b1, 1'b0, 1'b1);
        chk("flush_count", int'(c0), 0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);

        // Fill, then reset asynchronously and resume streaming.
        cycle(8'h51, 1'b1, 1'b0, 1'b0);
        cycle(8'h52, 1'b1, 1'b0, 1'b0);
        cycle(8'h53, 1'b1, 1'b0, 1'b0);
        async_reset();
        cycle(8'h61, 1'b1, 1'b0, 1'b0);
        cycle(8'h62, 1'b1, 1'b0, 1'b0);

        // Randomised traffic with occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            cycle(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 24) == 0);
            if ((i % 150) == 149) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reggy_pipe.md
Name: reggy_pipe

Overview:
- Parametrised multi-stage pipeline register: W-bit payload plus a valid bit per stage, DEPTH stages deep.
- Adds stall, flush, back-pressure (in_ready) and an optional bubble-collapsing mode, none of which a plain stage register has.
- Used between datapath stages where data must be carried several cycles and the pipeline must be stalled or squashed, e.g. on hazards or branch mispredicts.
- Stage 0 captures the input. Stage DEPTH-1 drives the output.

Parameters:
- W, 8, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- COLLAPSE, 0, stall mode. 0 = global stall, where every stage holds. 1 = bubble-collapsing, where stages behind an empty slot keep advancing.
- RESET_VAL, 0, W-bit value loaded into every data stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  W  payload offered to stage 0.
- in_valid  input  1  in_data is meaningful this cycle.
- in_ready  output  1  stage 0 will load this edge. Combinational.
- stall  input  1  downstream not accepting: the output stage must hold.
- flush  input  1  squash every in-flight entry.
- out_data  output  W  payload of stage DEPTH-1.
- out_valid  output  1  valid bit of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages. Registered, not recomputed combinationally.

Behaviour:
- Reset (async, rst=1):
  - all valid bits 0, all data stages RESET_VAL, count 0.
  - out_valid=0, out_data=RESET_VAL.
  - Outputs reach these values immediately, without a clock edge.
- Stage enables, en[k] for k=0..DEPTH-1:
  - COLLAPSE=0: en[k] = !stall for all k.
  - COLLAPSE=1: en[DEPTH-1] = !stall | !v[DEPTH-1]; en[k] = en[k+1] | !v[k].
- in_ready = en[0]. Under COLLAPSE=0 this equals !stall.
- On each rising edge, for a stage with en[k]=1:
  - stage 0 loads in_data and sets v[0]=in_valid.
  - stage k>0 loads data and valid from stage k-1.
  - data is loaded even when the incoming valid is 0.
  - A stage with en[k]=0 holds data and valid.
- A source entry moving into the next stage leaves behind whatever its own stage loads. Entries are never duplicated or lost.
- Latency with stall=0: an input accepted at edge t appears on out_data/out_valid after edge t+DEPTH-1. This is DEPTH register delays, the same as chaining DEPTH plain stage registers.
- flush=1 at an edge:
  - all v[k] cleared to 0 and count 0, regardless of stall or in_valid.
  - an input offered in the same cycle is dropped.
  - data registers may load or hold as normal; only valids are guaranteed.
  - flush takes priority over stall and load.
- count:
  - next = current + (entry accepted: in_valid & en[0]) − (entry retired: out_valid & !stall).
  - Under COLLAPSE=0 with stall=0 the retire term still applies.
  - Forced to 0 by flush.
  - Never exceeds DEPTH and never underflows.
- Full pipeline:
  - COLLAPSE=1, all stages valid, stall=1 → in_ready=0 and the pipeline is frozen.
  - COLLAPSE=0, stall=1 → frozen regardless of occupancy; in_ready=0.
- DEPTH=1: single stage. en[0] = !stall (COLLAPSE=0) or !stall | !v[0] (COLLAPSE=1).
- rst asserted mid-operation: immediate return to reset state, in-flight data discarded. First load occurs on the first edge after rst deasserts.
- No combinational path from in_data to out_data.

Test Plan:
- W=8, DEPTH=3, COLLAPSE=0: stream 0x11,0x22,0x33 with in_valid=1, stall=0 → out 0x11 valid after the 3rd edge, then 0x22, 0x33 on consecutive edges; count steps 1,2,3 then holds at 3; out_valid drops 3 edges after in_valid falls.
- Same config: assert stall for 2 cycles with 3 entries in flight → out_data and count frozen, in_ready=0; on release the stream resumes in order with no loss or duplication.
- COLLAPSE=1, DEPTH=3: entries A and B separated by one bubble, stall=1 → A holds at output, B advances into the bubble, in_ready=1 until all 3 stages are valid, then in_ready=0 and count=3.
- flush pulse with count=3 and in_valid=1 → next cycle count=0, out_valid=0, and the flushed-cycle input never appears at the output.
- rst asserted asynchronously between edges with a full pipeline → out_valid=0, out_data=RESET_VAL (e.g. 0xA5), count=0 before the next edge; normal streaming resumes after release.
- DEPTH=1, COLLAPSE=1: stall=1 with empty stage → accepts one entry, then in_ready=0; releasing stall retires it and count returns to 0 if in_valid=0.
